miriscv_mem_arbiter: RTL and testbench
======================================

MIRISCV_MEM_ARBITER -- requirements
Module: miriscv_mem_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address width.
REQ-002 SHALL have parameter DEPTH, default 2, max outstanding memory transactions.
REQ-003 SHALL have parameter STARVE_LIMIT, default 4, denied instr cycles before instr gets forced priority.
REQ-004 SHALL have ports, with clock and reset first:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous and active-high.
- instr_req_i  in  1  fetch request.
- instr_addr_i  in  XLEN  fetch address.
- instr_flush_i  in  1  discard all pending fetch responses.
- instr_gnt_o  out  1  fetch request accepted.
- instr_rvalid_o  out  1  fetch response valid.
- instr_rdata_o  out  XLEN  fetch response data.
- data_req_i  in  1  LSU request.
- data_we_i  in  1  LSU write enable.
- data_be_i  in  XLEN/8  LSU byte enables.
- data_addr_i  in  XLEN  LSU address.
- data_wdata_i  in  XLEN  LSU write data.
- data_gnt_o  out  1  LSU request accepted.
- data_rvalid_o  out  1  LSU response valid.
- data_rdata_o  out  XLEN  LSU response data.
- mem_req_o  out  1  memory request.
- mem_we_o  out  1  memory write enable.
- mem_be_o  out  XLEN/8  memory byte enables.
- mem_addr_o  out  XLEN  memory address.
- mem_wdata_o  out  XLEN  memory write data.
- mem_gnt_i  in  1  memory accepted request.
- mem_rvalid_i  in  1  memory response valid, in order.
- mem_rdata_i  in  XLEN  memory response data.
- resp_err_o  out  1  sticky: response received with no outstanding transaction.

Function
REQ-005 SHALL implement an FSM with states IDLE, HOLD_I and HOLD_D.
REQ-006 In IDLE, selection SHALL pick data if data_req_i=1, unless the starve counter equals STARVE_LIMIT and instr_req_i=1, in which case it SHALL pick instr; otherwise it SHALL pick instr if instr_req_i=1.
REQ-007 In HOLD_I or HOLD_D, selection SHALL stay fixed on the held requester.
REQ-008 mem_req_o SHALL equal (selected requester's req) AND (outstanding FIFO not full).
REQ-009 mem_we_o, mem_be_o and mem_wdata_o SHALL carry data fields when data is selected; otherwise they SHALL be 0, and mem_addr_o SHALL carry the selected requester's address.
REQ-010 Handshake occurs when mem_req_o=1 and mem_gnt_i=1; the selected requester's gnt_o SHALL be 1 that cycle, and the other requester's gnt_o SHALL be 0.
REQ-011 On mem_req_o=1 and mem_gnt_i=0, the FSM SHALL go to the HOLD_x state of the selected requester.
REQ-012 On a handshake, the FSM SHALL return to IDLE.
REQ-013 In HOLD_x, if the held requester's req drops, the FSM SHALL return to IDLE next cycle.
REQ-014 The outstanding FIFO SHALL hold DEPTH entries of {owner, discard}.
REQ-015 Each handshake SHALL push {owner, discard=0}.
REQ-016 Each mem_rvalid_i SHALL pop the FIFO head.
REQ-017 A simultaneous push and pop SHALL leave the occupancy unchanged.
REQ-018 On a pop with owner=instr and discard=0, instr_rvalid_o SHALL be 1; with owner=data, data_rvalid_o SHALL be 1; a discarded entry SHALL assert neither; all in the same cycle as mem_rvalid_i.
REQ-019 instr_rdata_o and data_rdata_o SHALL both equal mem_rdata_i combinationally.
REQ-020 instr_flush_i=1 SHALL set discard on every instr entry in the FIFO, including an instr entry pushed in the same cycle.
REQ-021 instr_flush_i SHALL suppress instr_rvalid_o in the same cycle.
REQ-022 The starve counter SHALL increment, saturating at STARVE_LIMIT, on each cycle with instr_req_i=1 and instr_gnt_o=0.
REQ-023 The starve counter SHALL clear on instr_gnt_o=1 or instr_req_i=0.
REQ-024 mem_rvalid_i with an empty FIFO SHALL be ignored (no rvalid outputs, FIFO unchanged) and SHALL set resp_err_o, which holds until reset.
REQ-025 Arbitration latency SHALL be zero cycles: req_i to mem_req_o is combinational.

Reset
REQ-026 While rst_i=1 at a clk_i edge, the FSM SHALL go to IDLE, the FIFO SHALL empty, the starve counter SHALL be 0 and resp_err_o SHALL be 0.
REQ-027 While rst_i=1, mem_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o and data_rvalid_o SHALL be 0.
REQ-028 Outstanding transactions SHALL be dropped by a mid-operation reset, and late responses after reset SHALL set resp_err_o.

Verification
REQ-029 Both req=1, mem_gnt_i=1 every cycle, STARVE_LIMIT=4 -> data granted 4 cycles, instr granted on cycle 5, pattern repeats.
REQ-030 instr selected at 0x100, mem_gnt_i=0 for 3 cycles, data_req_i rises in cycle 2 -> mem_addr_o stays 0x100 and FSM stays HOLD_I until grant; data then granted next.
REQ-031 DEPTH=2, two instr grants, then a third request -> mem_req_o=0 until first mem_rvalid_i; rdata 0xDEADBEEF appears on instr_rvalid_o.
REQ-032 Two instr entries outstanding, instr_flush_i pulse, then two mem_rvalid_i -> instr_rvalid_o stays 0; a subsequent instr fetch response is delivered.
REQ-033 Interleaved data-write and instr grants -> responses routed to owners in grant order.
REQ-034 mem_rvalid_i with empty FIFO -> resp_err_o=1 until rst_i; rst_i with 1 entry outstanding -> FIFO empty, outputs 0.

Source files
------------

// File: rtl/miriscv_mem_arbiter.sv
// Two-port memory arbiter: merges the fetch and LSU request streams onto one
// memory port, tracks outstanding transactions in order and routes responses
// back to their owner. Fetch gets forced priority after repeated denial.
module miriscv_mem_arbiter #(
    parameter int XLEN         = 32,
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              instr_req_i,
    input  logic [XLEN-1:0]   instr_addr_i,
    input  logic              instr_flush_i,
    output logic              instr_gnt_o,
    output logic              instr_rvalid_o,
    output logic [XLEN-1:0]   instr_rdata_o,

    input  logic              data_req_i,
    input  logic              data_we_i,
    input  logic [XLEN/8-1:0] data_be_i,
    input  logic [XLEN-1:0]   data_addr_i,
    input  logic [XLEN-1:0]   data_wdata_i,
    output logic              data_gnt_o,
    output logic              data_rvalid_o,
    output logic [XLEN-1:0]   data_rdata_o,

    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [XLEN/8-1:0] mem_be_o,
    output logic [XLEN-1:0]   mem_addr_o,
    output logic [XLEN-1:0]   mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [XLEN-1:0]   mem_rdata_i,

    output logic              resp_err_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, HOLD_I, HOLD_D} state_t;

    state_t          state, state_nxt;
    logic [DEPTH-1:0] own_q;   // 1 = data owns the entry, 0 = fetch
    logic [DEPTH-1:0] dis_q;   // response is to be swallowed
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count;
    logic [SW-1:0]   starve;

    logic sel_data, sel_req, full, empty, starve_max, hs, pop;
    logic head_own, head_dis;

    assign full       = (count == CW'(DEPTH));
    assign empty      = (count == '0);
    assign starve_max = (starve == SW'(STARVE_LIMIT));
    assign head_own   = own_q[rd_ptr];
    assign head_dis   = dis_q[rd_ptr];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Requester selection, memory request and next-state logic
    always_comb begin
        state_nxt = state;
        sel_data  = 1'b0;
        case (state)
            HOLD_I:  sel_data = 1'b0;
            HOLD_D:  sel_data = 1'b1;
            default: sel_data = data_req_i && !(starve_max && instr_req_i);
        endcase
        sel_req   = sel_data ? data_req_i : instr_req_i;
        mem_req_o = sel_req && !full && !rst_i;
        hs        = mem_req_o && mem_gnt_i;
        if (hs)
            state_nxt = IDLE;
        else if (mem_req_o)
            state_nxt = sel_data ? HOLD_D : HOLD_I;
        else if (!sel_req)
            state_nxt = IDLE;
    end

    assign mem_addr_o  = sel_data ? data_addr_i : instr_addr_i;
    assign mem_we_o    = sel_data && data_we_i;
    assign mem_be_o    = sel_data ? data_be_i : '0;
    assign mem_wdata_o = sel_data ? data_wdata_i : '0;

    assign instr_gnt_o = hs && !sel_data;
    assign data_gnt_o  = hs && sel_data;

    // A response only counts if something is outstanding
    assign pop            = mem_rvalid_i && !empty && !rst_i;
    assign instr_rvalid_o = pop && !head_own && !head_dis && !instr_flush_i;
    assign data_rvalid_o  = pop && head_own;
    assign instr_rdata_o  = mem_rdata_i;
    assign data_rdata_o   = mem_rdata_i;

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    // Outstanding-transaction FIFO; a flush marks every fetch entry, including
    // one being pushed this cycle, so its response is dropped on arrival
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            own_q  <= '0;
            dis_q  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (instr_flush_i)
                dis_q <= dis_q | ~own_q;
            if (hs) begin
                own_q[wr_ptr] <= sel_data;
                dis_q[wr_ptr] <= instr_flush_i && !sel_data;
                wr_ptr        <= ptr_inc(wr_ptr);
            end
            if (pop)
                rd_ptr <= ptr_inc(rd_ptr);
            case ({hs, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Fetch starvation counter, saturating
    always_ff @(posedge clk_i) begin
        if (rst_i)
            starve <= '0;
        else if (instr_req_i && !instr_gnt_o)
            starve <= starve_max ? starve : starve + 1'b1;
        else
            starve <= '0;
    end

    // Sticky flag for a response that had no matching request
    always_ff @(posedge clk_i) begin
        if (rst_i)
            resp_err_o <= 1'b0;
        else if (mem_rvalid_i && empty)
            resp_err_o <= 1'b1;
    end

endmodule

// File: tb/tb_miriscv_mem_arbiter.sv
// Bench for miriscv_mem_arbiter: a queue-based reference model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_miriscv_mem_arbiter;
    localparam int XLEN = 32;
    localparam int DEPTH = 2;
    localparam int LIM = 4;

    logic clk = 1'b0;
    logic rst;
    logic instr_req, instr_flush, instr_gnt_o, instr_rvalid_o;
    logic [XLEN-1:0] instr_addr, instr_rdata_o;
    logic data_req, data_we, data_gnt_o, data_rvalid_o;
    logic [XLEN/8-1:0] data_be, mem_be_o;
    logic [XLEN-1:0] data_addr, data_wdata, data_rdata_o;
    logic mem_req_o, mem_we_o, mem_gnt, mem_rvalid, resp_err_o;
    logic [XLEN-1:0] mem_addr_o, mem_wdata_o, mem_rdata;

    int checks = 0;
    int errors = 0;

    miriscv_mem_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH), .STARVE_LIMIT(LIM)) dut (
        .clk_i(clk), .rst_i(rst),
        .instr_req_i(instr_req), .instr_addr_i(instr_addr), .instr_flush_i(instr_flush),
        .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o),
        .data_req_i(data_req), .data_we_i(data_we), .data_be_i(data_be),
        .data_addr_i(data_addr), .data_wdata_i(data_wdata),
        .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
        .resp_err_o(resp_err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: in-order queue of {owner, discard}; held = 0 none, 1 fetch, 2 data
    bit q_own[$];
    bit q_dis[$];
    int held = 0;
    int starve = 0;
    bit err_m = 0;

    // Per-cycle compare against the model, then advance the model
    always @(negedge clk) begin
        bit sd, sreq, emreq, hs, eir, edr;
        chk("m_resp_err", resp_err_o, err_m);
        if (rst) begin
            chk("m_rst_mem_req", mem_req_o, 0);
            chk("m_rst_gnts", {instr_gnt_o, data_gnt_o}, 0);
            chk("m_rst_rvalids", {instr_rvalid_o, data_rvalid_o}, 0);
            q_own.delete();
            q_dis.delete();
            held = 0;
            starve = 0;
            err_m = 0;
        end else begin
            if (held == 1)      sd = 0;
            else if (held == 2) sd = 1;
            else                sd = data_req && !(starve == LIM && instr_req);
            sreq  = sd ? data_req : instr_req;
            emreq = sreq && (q_own.size() < DEPTH);
            hs    = emreq && mem_gnt;
            eir = 0;
            edr = 0;
            if (mem_rvalid && q_own.size() > 0) begin
                if (q_own[0]) edr = 1;
                else          eir = !q_dis[0] && !instr_flush;
            end
            chk("m_mem_req", mem_req_o, emreq);
            if (emreq) chk("m_mem_addr", mem_addr_o, sd ? data_addr : instr_addr);
            chk("m_mem_we", mem_we_o, sd && data_we);
            chk("m_mem_be", mem_be_o, sd ? data_be : 0);
            chk("m_mem_wdata", mem_wdata_o, sd ? data_wdata : 0);
            chk("m_instr_gnt", instr_gnt_o, hs && !sd);
            chk("m_data_gnt", data_gnt_o, hs && sd);
            chk("m_instr_rvalid", instr_rvalid_o, eir);
            chk("m_data_rvalid", data_rvalid_o, edr);
            if (eir) chk("m_instr_rdata", instr_rdata_o, mem_rdata);
            if (edr) chk("m_data_rdata", data_rdata_o, mem_rdata);
            // advance
            if (instr_flush)
                foreach (q_own[i]) if (!q_own[i]) q_dis[i] = 1;
            if (mem_rvalid) begin
                if (q_own.size() == 0) err_m = 1;
                else begin
                    void'(q_own.pop_front());
                    void'(q_dis.pop_front());
                end
            end
            if (hs) begin
                q_own.push_back(sd);
                q_dis.push_back(instr_flush && !sd);
            end
            if (hs)         held = 0;
            else if (emreq) held = sd ? 2 : 1;
            else if (!sreq) held = 0;
            if (instr_req && !(hs && !sd)) starve = (starve < LIM) ? starve + 1 : LIM;
            else                           starve = 0;
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    logic [9:0] ig, dg;

    initial begin
        rst = 1; instr_req = 1; instr_addr = 0; instr_flush = 0;
        data_req = 1; data_we = 0; data_be = 0; data_addr = 0; data_wdata = 0;
        mem_gnt = 1; mem_rvalid = 0; mem_rdata = 0;
        nxt();
        @(negedge clk);
        chk("reset_mem_req", mem_req_o, 0);
        chk("reset_resp_err", resp_err_o, 0);
        nxt();

        // Starvation: data wins 4 times, fetch forced on the 5th
        rst = 0; instr_addr = 32'h100; data_we = 1; data_be = 4'hF;
        data_addr = 32'h200; data_wdata = 32'h55;
        for (int k = 0; k < 10; k++) begin
            mem_rvalid = (k > 0);
            mem_rdata = 32'h1000 + k;
            @(negedge clk);
            ig[k] = instr_gnt_o;
            dg[k] = data_gnt_o;
            nxt();
        end
        chk("starve_instr_pattern", {22'd0, ig}, 32'h210);
        chk("starve_data_pattern", {22'd0, dg}, 32'h1EF);
        instr_req = 0; data_req = 0; mem_rvalid = 1; mem_rdata = 32'h2000;
        nxt();
        mem_rvalid = 0;

        // Held fetch keeps its address while data arrives
        instr_req = 1; instr_addr = 32'h100; mem_gnt = 0;
        data_we = 0; data_be = 4'h3; data_addr = 32'h300; data_wdata = 32'h99;
        nxt();
        data_req = 1;
        @(negedge clk); chk("hold_i_addr_c1", mem_addr_o, 32'h100);
        nxt();
        @(negedge clk); chk("hold_i_addr_c2", mem_addr_o, 32'h100); chk("hold_i_no_dgnt", data_gnt_o, 0);
        nxt();
        mem_gnt = 1;
        @(negedge clk); chk("hold_i_grant", instr_gnt_o, 1);
        nxt();
        @(negedge clk); chk("data_after_hold", data_gnt_o, 1);
        nxt();
        instr_req = 0; data_req = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'hA1;
        @(negedge clk); chk("hold_resp_instr", instr_rvalid_o, 1);
        nxt();
        mem_rdata = 32'hA2;
        @(negedge clk); chk("hold_resp_data", data_rvalid_o, 1);
        nxt();
        mem_rvalid = 0;

        // FIFO full blocks a third fetch
        instr_req = 1; instr_addr = 32'h400; mem_gnt = 1;
        nxt(); nxt();
        @(negedge clk); chk("fifo_full_c2", mem_req_o, 0);
        nxt();
        @(negedge clk); chk("fifo_full_c3", mem_req_o, 0);
        nxt();
        mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("full_resp_rvalid", instr_rvalid_o, 1);
        chk("full_resp_rdata", instr_rdata_o, 32'hDEADBEEF);
        nxt();
        mem_rvalid = 0;
        @(negedge clk); chk("full_then_grant", instr_gnt_o, 1);
        nxt();
        instr_req = 0; mem_rvalid = 1; mem_rdata = 32'hB1;
        nxt();
        mem_rdata = 32'hB2;
        nxt();
        mem_rvalid = 0;

        // Flush discards outstanding fetch responses
        instr_req = 1; instr_addr = 32'h600;
        nxt(); nxt();
        instr_req = 0; instr_flush = 1;
        nxt();
        instr_flush = 0; mem_rvalid = 1; mem_rdata = 32'hE1;
        @(negedge clk); chk("flush_drop_1", instr_rvalid_o, 0);
        nxt();
        mem_rdata = 32'hE2;
        @(negedge clk); chk("flush_drop_2", instr_rvalid_o, 0);
        nxt();
        mem_rvalid = 0; instr_req = 1; instr_flush = 1;
        nxt();
        instr_req = 0; instr_flush = 0; mem_rvalid = 1; mem_rdata = 32'hE3;
        @(negedge clk); chk("flush_same_cycle_push", instr_rvalid_o, 0);
        nxt();
        mem_rvalid = 0; instr_req = 1;
        nxt();
        instr_req = 0; mem_rvalid = 1; instr_flush = 1; mem_rdata = 32'hE4;
        @(negedge clk); chk("flush_same_cycle_pop", instr_rvalid_o, 0);
        nxt();
        mem_rvalid = 0; instr_flush = 0; instr_req = 1;
        nxt();
        instr_req = 0; mem_rvalid = 1; mem_rdata = 32'h00C0FFEE;
        @(negedge clk); chk("post_flush_deliver", instr_rvalid_o, 1);
        nxt();
        mem_rvalid = 0;

        // Interleaved data write / fetch, responses in grant order
        data_req = 1; data_we = 1; data_be = 4'hF; data_addr = 32'h500; data_wdata = 32'h77;
        nxt();
        data_req = 0; instr_req = 1; instr_addr = 32'h700;
        nxt();
        instr_req = 0; data_req = 1; mem_rvalid = 1; mem_rdata = 32'hD0;
        @(negedge clk); chk("ilv_resp0_data", data_rvalid_o, 1); chk("ilv_resp0_noinstr", instr_rvalid_o, 0);
        nxt();
        mem_rdata = 32'hD1;
        @(negedge clk); chk("ilv_resp1_instr", instr_rvalid_o, 1); chk("ilv_held_data_gnt", data_gnt_o, 1);
        nxt();
        data_req = 0; mem_rdata = 32'hD2;
        @(negedge clk); chk("ilv_resp2_data", data_rvalid_o, 1);
        nxt();
        mem_rvalid = 0;

        // Spurious response, then reset with one outstanding
        mem_rvalid = 1; mem_rdata = 32'hF0;
        @(negedge clk); chk("spurious_no_rvalid", {instr_rvalid_o, data_rvalid_o}, 0);
        nxt();
        mem_rvalid = 0;
        @(negedge clk); chk("resp_err_set", resp_err_o, 1);
        nxt(); nxt();
        @(negedge clk); chk("resp_err_sticky", resp_err_o, 1);
        instr_req = 1;
        nxt();
        rst = 1; mem_rvalid = 1;
        @(negedge clk); chk("rst_mem_req_0", mem_req_o, 0); chk("rst_rvalid_0", instr_rvalid_o, 0);
        nxt();
        rst = 0; instr_req = 0; mem_rvalid = 0;
        @(negedge clk); chk("rst_clears_err", resp_err_o, 0);
        nxt();
        mem_rvalid = 1; mem_rdata = 32'hF1;
        @(negedge clk); chk("late_resp_dropped", instr_rvalid_o, 0);
        nxt();
        mem_rvalid = 0;
        @(negedge clk); chk("late_resp_err", resp_err_o, 1);
        nxt();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
